// File: rtl/alu_nibble_sequencer.sv
// Runs a WORDS x 4-bit ALU operation through one external 4-bit ALU slice.
// One nibble is processed per clock, least-significant first, with the carry held in a register.
module alu_nibble_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [4*WORDS-1:0] op_a,
    input  logic [4*WORDS-1:0] op_b,
    input  logic [3:0]         op_s,
    input  logic               op_m,
    input  logic               op_cin,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [3:0]         alu_s,
    output logic               alu_m,
    output logic               alu_pin,
    input  logic [3:0]         alu_r,
    input  logic               alu_pout,
    output logic [4*WORDS-1:0] result,
    output logic               cout,
    output logic               zero,
    output logic               done
);

    localparam int unsigned KW = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [4*WORDS-1:0] a_q, a_d, b_q, b_d;
    logic [4*WORDS-1:0] acc_q, acc_d, result_q, result_d;
    logic [3:0]         s_q, s_d;
    logic               m_q, m_d, carry_q, carry_d, cout_q, cout_d;
    logic [KW-1:0]      k_q, k_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            s_q      <= s_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            k_q      <= k_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        s_d      = s_q;
        m_d      = m_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        k_d      = k_q;
        ready    = 1'b0;
        done     = 1'b0;
        alu_a    = 4'h0;
        alu_b    = 4'h0;

        for (int i = 0; i < int'(WORDS); i++) begin
            if (k_q == KW'(i)) begin
                alu_a = a_q[4*i +: 4];
                alu_b = b_q[4*i +: 4];
            end
        end

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    s_d     = op_s;
                    m_d     = op_m;
                    carry_d = op_cin;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(WORDS); i++) begin
                    if (k_q == KW'(i)) begin
                        acc_d[4*i +: 4] = alu_r;
                    end
                end
                carry_d = alu_pout;
                if (k_q == KW'(WORDS - 1)) begin
                    // Publish on the last RUN edge so result is valid with done.
                    result_d = acc_d;
                    cout_d   = alu_pout;
                    k_d      = '0;
                    state_d  = StDone;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign alu_s   = s_q;
    assign alu_m   = m_q;
    assign alu_pin = carry_q;
    assign result  = result_q;
    assign cout    = cout_q;
    assign zero    = (result_q == '0);

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 4-bit ALU slice
// and a scoreboard of wide expected results.
module tb_alu_nibble_sequencer;

    localparam int unsigned WORDS = 4;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [15:0] op_a, op_b;
    logic [3:0]  op_s;
    logic        op_m, op_cin;
    logic [3:0]  alu_a, alu_b, alu_s, alu_r;
    logic        alu_m, alu_pin, alu_pout;
    logic [15:0] result;
    logic        cout, zero, done;

    int n_assert = 0;
    int n_fail   = 0;
    logic [16:0] sb_q[$];
    logic [3:0]  pin_trace;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_s     (op_s),
        .op_m     (op_m),
        .op_cin   (op_cin),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_m    (alu_m),
        .alu_pin  (alu_pin),
        .alu_r    (alu_r),
        .alu_pout (alu_pout),
        .result   (result),
        .cout     (cout),
        .zero     (zero),
        .done     (done)
    );

    // Behavioural ALU slice: add with carry, or XOR (no carry out in logic mode).
    always_comb begin
        alu_r    = 4'h0;
        alu_pout = 1'b0;
        if (!alu_m && alu_s == 4'b1001) begin
            {alu_pout, alu_r} = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_pin};
        end else if (alu_m && alu_s == 4'b0110) begin
            alu_r = alu_a ^ alu_b;
        end
    end

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m, input logic cin);
        if (!m && s == 4'b1001) return {1'b0, a} + {1'b0, b} + {16'h0, cin};
        if (m && s == 4'b0110) return {1'b0, a ^ b};
        return 17'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cin);
        check("ready_before_start", 32'(ready), 32'd1);
        op_a   = a;
        op_b   = b;
        op_s   = s;
        op_m   = m;
        op_cin = cin;
        start  = 1'b1;
        sb_q.push_back(model(a, b, s, m, cin));
        tick();
        start  = 1'b0;
    endtask

    // lat0: cycles already elapsed since the accepting edge.
    task automatic wait_done(input int lat0);
        logic [16:0] exp;
        int lat;
        bit got;
        lat = lat0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (lat < 4) pin_trace[lat] = alu_pin;
            tick();
            lat++;
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("latency_cycle", 32'(lat + 1), 32'(WORDS + 1));
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h1ffff;
            check("result", 32'(result), 32'(exp[15:0]));
            check("cout", 32'(cout), 32'(exp[16]));
            check("zero", 32'(zero), 32'(exp[15:0] == 16'h0));
            tick();
            check("done_single_pulse", 32'(done), 32'd0);
            check("ready_after_done", 32'(ready), 32'd1);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op_a   = 16'h0;
        op_b   = 16'h0;
        op_s   = 4'h0;
        op_m   = 1'b0;
        op_cin = 1'b0;
        pin_trace = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_alu", {19'h0, alu_a, alu_b, alu_s, alu_m}, 32'h0);
        check("rst_alu_pin", 32'(alu_pin), 32'd0);

        // Full carry ripple through all nibbles.
        issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        wait_done(0);
        check("pin_trace", 32'(pin_trace), 32'hE);

        issue(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1);
        wait_done(0);

        issue(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b0);
        wait_done(0);

        // Start pulsed in cycle 2 with other operands must be ignored.
        issue(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b0);
        tick();
        op_a  = 16'hFFFF;
        op_b  = 16'h0001;
        op_cin = 1'b1;
        start = 1'b1;
        check("busy_ready", 32'(ready), 32'd0);
        tick();
        start = 1'b0;
        wait_done(2);
        for (int i = 0; i < 4; i++) begin
            check("busy_no_extra_done", 32'(done), 32'd0);
            tick();
        end

        // Reset asserted in RUN cycle 3 discards the operation.
        issue(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb_q.pop_back());
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_zero", 32'(zero), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("midrst_no_done", 32'(done), 32'd0);
            tick();
        end
        issue(16'h0F0F, 16'h00F1, 4'b1001, 1'b0, 1'b0);
        wait_done(0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
